// File: rtl/noc_pkg.sv
// Shared router definitions: widths, port indices, packet field layout and
// the occupancy encoding used by the per-port output FIFO.
package noc_pkg;

   localparam int unsigned DATA_WIDTH = 64;
   localparam int unsigned NUM_IN     = 5;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_WIDTH  = 16;

   localparam int unsigned PE = 0;
   localparam int unsigned L  = 1;
   localparam int unsigned R  = 2;
   localparam int unsigned U  = 3;
   localparam int unsigned D  = 4;

   localparam int unsigned DIR_X_BIT    = 62;
   localparam int unsigned DIR_Y_BIT    = 61;
   localparam int unsigned HOP_X_MSB    = 55;
   localparam int unsigned HOP_X_LSB    = 52;
   localparam int unsigned HOP_Y_MSB    = 51;
   localparam int unsigned HOP_Y_LSB    = 48;
   localparam int unsigned SOURCE_X_MSB = 47;
   localparam int unsigned SOURCE_X_LSB = 40;
   localparam int unsigned SOURCE_Y_MSB = 39;
   localparam int unsigned SOURCE_Y_LSB = 32;

   typedef enum logic [1:0] {
      FIFO_EMPTY = 2'd0,
      FIFO_ONE   = 2'd1,
      FIFO_FULL  = 2'd2
   } fifo_state_e;

   function automatic logic [3:0] pkt_hop_x(input logic [DATA_WIDTH-1:0] pkt);
      return pkt[HOP_X_MSB:HOP_X_LSB];
   endfunction

   function automatic logic [3:0] pkt_hop_y(input logic [DATA_WIDTH-1:0] pkt);
      return pkt[HOP_Y_MSB:HOP_Y_LSB];
   endfunction

   function automatic logic [7:0] pkt_source_x(input logic [DATA_WIDTH-1:0] pkt);
      return pkt[SOURCE_X_MSB:SOURCE_X_LSB];
   endfunction

   function automatic logic [7:0] pkt_source_y(input logic [DATA_WIDTH-1:0] pkt);
      return pkt[SOURCE_Y_MSB:SOURCE_Y_LSB];
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant searching from ptr upward,
// pointer moves just past the winner only when a grant is actually issued.
module rr_arbiter #(
   parameter int unsigned NUM_IN = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_IN-1:0] req,
   input  logic              enable,
   output logic [NUM_IN-1:0] gnt
);

   localparam int unsigned PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic          found;

   always_comb begin
      gnt   = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         int unsigned idx;
         idx = k + ptr_q;
         if (idx >= NUM_IN) idx = idx - NUM_IN;
         if (enable && !found && req[PW'(idx)]) begin
            found           = 1'b1;
            gnt[PW'(idx)]   = 1'b1;
            ptr_d           = (idx + 1 == NUM_IN) ? '0 : PW'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output-port arbiter: round-robin selects one requesting input per cycle
// into a 2-entry FIFO that drives the outgoing valid/ready link.
module output_port_arbiter #(
   parameter int unsigned DATA_WIDTH = noc_pkg::DATA_WIDTH,
   parameter int unsigned NUM_IN     = noc_pkg::NUM_IN,
   parameter int unsigned FIFO_DEPTH = noc_pkg::FIFO_DEPTH,
   parameter int unsigned CNT_WIDTH  = noc_pkg::CNT_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_IN-1:0]            reqIn,
   input  logic [NUM_IN*DATA_WIDTH-1:0] dataIn,
   output logic [NUM_IN-1:0]            gntOut,
   output logic                         validOut,
   output logic [DATA_WIDTH-1:0]        dataOut,
   input  logic                         readyIn,
   output logic [CNT_WIDTH-1:0]         pktCount
);

   import noc_pkg::*;

   fifo_state_e           state_q, state_d;
   logic                  rd_q, rd_d;
   logic                  wr_q, wr_d;
   logic [CNT_WIDTH-1:0]  pkt_q, pkt_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic                  push, pop, space, arb_en;
   logic [DATA_WIDTH-1:0] push_data;

   assign validOut = (state_q != FIFO_EMPTY);
   assign pop      = validOut & readyIn;
   // A full FIFO still has room when its head leaves on this same edge.
   assign space    = (state_q != FIFO_FULL) | pop;
   assign arb_en   = space & ~reset;

   rr_arbiter #(
      .NUM_IN (NUM_IN)
   ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (reqIn),
      .enable (arb_en),
      .gnt    (gntOut)
   );

   assign push = |gntOut;

   always_comb begin
      push_data = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (gntOut[i]) push_data = push_data | dataIn[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FIFO_EMPTY: if (push) state_d = FIFO_ONE;
         FIFO_ONE: begin
            if (push && !pop)      state_d = FIFO_FULL;
            else if (!push && pop) state_d = FIFO_EMPTY;
         end
         FIFO_FULL:  if (pop && !push) state_d = FIFO_ONE;
         default:    state_d = FIFO_EMPTY;
      endcase
      rd_d  = rd_q ^ pop;
      wr_d  = wr_q ^ push;
      pkt_d = pkt_q + CNT_WIDTH'(push);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FIFO_EMPTY;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         pkt_q   <= pkt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= push_data;
   end

   assign dataOut  = validOut ? mem_q[rd_q] : '0;
   assign pktCount = pkt_q;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: vector table for arbitration and
// backpressure, plus hand sequences for reset, async reset and counter wrap.
module tb_output_port_arbiter;

   logic         clk;
   logic         reset;
   logic [4:0]   reqIn;
   logic [319:0] dataIn;
   logic [4:0]   gntOut;
   logic         validOut;
   logic [63:0]  dataOut;
   logic         readyIn;
   logic [15:0]  pktCount;

   int n_vec;
   int n_miss;

   logic [63:0] din [5];

   typedef struct {
      logic [4:0] req;
      logic       rdy;
      logic [4:0] gnt;
      logic       vld;
      int         head;
      int         cnt;
   } vec_t;

   vec_t tbl [29];

   output_port_arbiter #(
      .DATA_WIDTH (64),
      .NUM_IN     (5),
      .FIFO_DEPTH (2),
      .CNT_WIDTH  (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .reqIn    (reqIn),
      .dataIn   (dataIn),
      .gntOut   (gntOut),
      .validOut (validOut),
      .dataOut  (dataOut),
      .readyIn  (readyIn),
      .pktCount (pktCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic load_data();
      for (int i = 0; i < 5; i++) dataIn[i*64 +: 64] = din[i];
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      reqIn   = '0;
      readyIn = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      n_vec   = 0;
      n_miss  = 0;
      reset   = 1'b1;
      reqIn   = '0;
      readyIn = 1'b0;
      for (int i = 0; i < 5; i++) din[i] = 64'hC0DE_0000_0000_00A0 + 64'(i);
      load_data();

      tbl[0]  = '{5'b11111, 1'b1, 5'b00001, 1'b0, -1, 0};
      tbl[1]  = '{5'b11111, 1'b1, 5'b00010, 1'b1,  0, 1};
      tbl[2]  = '{5'b11111, 1'b1, 5'b00100, 1'b1,  1, 2};
      tbl[3]  = '{5'b11111, 1'b1, 5'b01000, 1'b1,  2, 3};
      tbl[4]  = '{5'b11111, 1'b1, 5'b10000, 1'b1,  3, 4};
      tbl[5]  = '{5'b11111, 1'b1, 5'b00001, 1'b1,  4, 5};
      tbl[6]  = '{5'b11111, 1'b1, 5'b00010, 1'b1,  0, 6};
      tbl[7]  = '{5'b11111, 1'b1, 5'b00100, 1'b1,  1, 7};
      tbl[8]  = '{5'b11111, 1'b1, 5'b01000, 1'b1,  2, 8};
      tbl[9]  = '{5'b11111, 1'b1, 5'b10000, 1'b1,  3, 9};
      tbl[10] = '{5'b00000, 1'b1, 5'b00000, 1'b1,  4, 10};
      tbl[11] = '{5'b00011, 1'b0, 5'b00001, 1'b0, -1, 10};
      tbl[12] = '{5'b00011, 1'b0, 5'b00010, 1'b1,  0, 11};
      tbl[13] = '{5'b00011, 1'b0, 5'b00000, 1'b1,  0, 12};
      tbl[14] = '{5'b00011, 1'b0, 5'b00000, 1'b1,  0, 12};
      tbl[15] = '{5'b00011, 1'b1, 5'b00001, 1'b1,  0, 12};
      tbl[16] = '{5'b00000, 1'b1, 5'b00000, 1'b1,  1, 13};
      tbl[17] = '{5'b00000, 1'b0, 5'b00000, 1'b1,  0, 13};
      tbl[18] = '{5'b00000, 1'b1, 5'b00000, 1'b1,  0, 13};
      tbl[19] = '{5'b00000, 1'b1, 5'b00000, 1'b0, -1, 13};
      tbl[20] = '{5'b01000, 1'b1, 5'b01000, 1'b0, -1, 13};
      tbl[21] = '{5'b00000, 1'b1, 5'b00000, 1'b1,  3, 14};
      tbl[22] = '{5'b00000, 1'b1, 5'b00000, 1'b0, -1, 14};
      tbl[23] = '{5'b00000, 1'b1, 5'b00000, 1'b0, -1, 14};
      tbl[24] = '{5'b01001, 1'b1, 5'b00001, 1'b0, -1, 14};
      tbl[25] = '{5'b00000, 1'b1, 5'b00000, 1'b1,  0, 15};
      tbl[26] = '{5'b00001, 1'b1, 5'b00001, 1'b0, -1, 15};
      tbl[27] = '{5'b10010, 1'b1, 5'b00010, 1'b1,  0, 16};
      tbl[28] = '{5'b00000, 1'b1, 5'b00000, 1'b1,  1, 17};

      // Reset, idle, then a single packet from input 2.
      do_reset();
      #1;
      chk("rst_valid", 64'(validOut), 64'd0);
      chk("rst_data",  dataOut,       64'd0);
      chk("rst_gnt",   64'(gntOut),   64'd0);
      chk("rst_cnt",   64'(pktCount), 64'd0);
      @(negedge clk);
      dataIn[2*64 +: 64] = 64'hA5;
      reqIn   = 5'b00100;
      readyIn = 1'b1;
      #1;
      chk("first_gnt",   64'(gntOut),   64'(5'b00100));
      chk("first_valid", 64'(validOut), 64'd0);
      @(negedge clk);
      reqIn = '0;
      #1;
      chk("first_valid_n1", 64'(validOut), 64'd1);
      chk("first_data_n1",  dataOut,       64'hA5);
      chk("first_cnt_n1",   64'(pktCount), 64'd1);
      load_data();

      // Table: fairness, backpressure, pointer hold/wrap.
      do_reset();
      for (int v = 0; v < 29; v++) begin
         @(negedge clk);
         reqIn   = tbl[v].req;
         readyIn = tbl[v].rdy;
         #1;
         chk($sformatf("v%0d_gnt", v),   64'(gntOut),   64'(tbl[v].gnt));
         chk($sformatf("v%0d_valid", v), 64'(validOut), 64'(tbl[v].vld));
         chk($sformatf("v%0d_data", v),  dataOut,
             (tbl[v].head < 0) ? 64'd0 : din[tbl[v].head]);
         chk($sformatf("v%0d_cnt", v),   64'(pktCount), 64'(tbl[v].cnt));
      end

      // Asynchronous reset with the FIFO full and pktCount at 7.
      do_reset();
      @(negedge clk);
      reqIn   = 5'b00001;
      readyIn = 1'b1;
      repeat (6) @(negedge clk);
      readyIn = 1'b0;
      @(negedge clk);
      #1;
      chk("full_valid", 64'(validOut), 64'd1);
      chk("full_cnt",   64'(pktCount), 64'd7);
      chk("full_gnt",   64'(gntOut),   64'd0);
      chk("full_data",  dataOut,       din[0]);
      #1;
      reset = 1'b1;
      #1;
      chk("arst_valid", 64'(validOut), 64'd0);
      chk("arst_data",  dataOut,       64'd0);
      chk("arst_cnt",   64'(pktCount), 64'd0);
      chk("arst_gnt",   64'(gntOut),   64'd0);
      @(negedge clk);
      #2;
      reset   = 1'b0;
      reqIn   = 5'b10100;
      readyIn = 1'b1;
      #1;
      chk("post_rst_gnt", 64'(gntOut), 64'(5'b00100));
      @(negedge clk);
      reqIn = '0;
      #1;
      chk("post_rst_data", dataOut, din[2]);

      // Counter wrap.
      do_reset();
      reqIn   = 5'b00001;
      readyIn = 1'b1;
      repeat (65535) @(posedge clk);
      @(negedge clk);
      #1;
      chk("wrap_cnt_max", 64'(pktCount), 64'd65535);
      chk("wrap_gnt",     64'(gntOut),   64'(5'b00001));
      @(negedge clk);
      reqIn = '0;
      #1;
      chk("wrap_cnt_zero", 64'(pktCount), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
